// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for the EX stage.
// Produces {remainder, quotient} for HI/LO after DATA_W iterations.
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic              neg_q;
  logic              neg_r;

  logic              op1_neg;
  logic              op2_neg;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              q_bit;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] dvd_nx;
  logic [DATA_W-1:0] quo_fin;
  logic [DATA_W-1:0] rem_fin;
  logic              last;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign abs1    = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs2    = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // Shifted remainder can reach DATA_W+1 bits; its top bit alone
  // guarantees the trial subtraction is non-negative.
  assign shifted = {rem, dvd[DATA_W-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign q_bit   = shifted[DATA_W] | ~trial[DATA_W];
  assign rem_nx  = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign dvd_nx  = {dvd[DATA_W-2:0], q_bit};

  assign quo_fin = neg_q ? (~dvd_nx + 1'b1) : dvd_nx;
  assign rem_fin = neg_r ? (~rem_nx + 1'b1) : rem_nx;
  assign last    = (cnt == CNT_W'(DATA_W - 1));

  assign busy_o  = (state == S_BYZERO) || (state == S_ON);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state <= S_ON;
              cnt   <= '0;
              rem   <= '0;
              dvd   <= abs1;
              dvs   <= abs2;
              neg_q <= op1_neg ^ op2_neg;
              neg_r <= op1_neg;
            end
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            state    <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            state    <= S_END;
            ready_o  <= 1'b1;
            result_o <= '0;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state   <= S_FREE;
            cnt     <= '0;
            ready_o <= 1'b0;
          end else begin
            rem <= rem_nx;
            dvd <= dvd_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
              state    <= S_END;
              ready_o  <= 1'b1;
              result_o <= {rem_fin, quo_fin};
            end
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            state    <= S_FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          state   <= S_FREE;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed checks for div_seq: latency, signs, div-by-zero,
// annul, overflow and asynchronous reset.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_chk;
  int n_pass;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Start at a falling edge, hold start until ready, then drop it.
  task automatic do_div(input string tag,
                        input logic sd,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] exp_res,
                        input int exp_lat);
    int lat;
    @(negedge clk);
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " busy_e0"}, 64'(busy_o), 64'd1);
    opdata1_i = 32'h1234_5678;
    opdata2_i = 32'h0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (ready_o) break;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    check({tag, " busy_rdy"}, 64'(busy_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ready_drop"}, 64'(ready_o), 64'd0);
    check({tag, " result_drop"}, result_o, 64'd0);
  endtask

  initial begin
    int seen;
    n_chk        = 0;
    n_pass       = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7,
           64'h00000002_0000000E, 32);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
           64'hFFFFFFFF_FFFFFFFD, 32);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
           64'h00000001_FFFFFFFD, 32);
    do_div("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
           64'hFFFFFFFF_00000003, 32);
    do_div("divz", 1'b0, 32'd55, 32'd0, 64'd0, 1);
    do_div("divz_s", 1'b1, 32'hFFFF_FFF0, 32'd0, 64'd0, 1);
    do_div("ovf_s", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h00000000_80000000, 32);
    do_div("ovf_u", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h80000000_00000000, 32);
    do_div("big_dvs", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001,
           64'h7FFFFFFE_00000001, 32);

    // Annul at iteration 10.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ready_o) seen++;
    end
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (ready_o) seen++;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    do_div("after_annul", 1'b0, 32'hFFFF_FFFF, 32'd1,
           64'h00000000_FFFFFFFF, 32);

    // Annul in FREE overrides start.
    @(negedge clk);
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    @(posedge clk);
    #1;
    check("annul_free_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;

    // Async reset between edges at iteration 20.
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i    = 32'd500;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_ready", 64'(ready_o), 64'd0);
    check("arst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_div("after_rst", 1'b1, 32'hFFFF_FC18, 32'd10,
           64'h00000000_FFFFFF9C, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
